// File: rtl/fifo_write_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : fifo_write_arbiter
// Purpose  : Round-robin arbiter that shares the write port of an async FIFO
//            among NREQ producers on the write clock. A grant lasts one burst
//            of up to MAXBURST beats. Writes are gated by the FIFO's
//            registered full flag.
// Ports    : wclk, wrst_n (async, active-low)
//            s_valid/s_last/s_data : per-requester word, end marker, data
//            wfull                 : registered FIFO full flag
//            s_ready               : per-requester ready (owner only, not full)
//            grant/gnt_id          : registered one-hot / binary owner
//            winc/wdata            : FIFO write strobe and data
//            busy                  : burst in progress
// Options  : WARB_PRIO0_EN - requester 0 wins every arbitration it takes
//            part in and does not advance the round-robin pointer.
// Revision : 1.0 - initial release
// ============================================================================
module fifo_write_arbiter #(
    parameter int NREQ     = 4,
    parameter int DSIZE    = 8,
    parameter int MAXBURST = 8
) (
    input  logic                      wclk,
    input  logic                      wrst_n,
    input  logic [NREQ-1:0]           s_valid,
    input  logic [NREQ-1:0]           s_last,
    input  logic [NREQ*DSIZE-1:0]     s_data,
    input  logic                      wfull,
    output logic [NREQ-1:0]           s_ready,
    output logic [NREQ-1:0]           grant,
    output logic [$clog2(NREQ)-1:0]   gnt_id,
    output logic                      winc,
    output logic [DSIZE-1:0]          wdata,
    output logic                      busy
);

    localparam int c_IW = $clog2(NREQ);
    localparam int c_CW = $clog2(MAXBURST) + 1;
    localparam logic [c_CW-1:0] c_MAXCNT = c_CW'(MAXBURST);
    localparam logic [NREQ-1:0] c_ONEHOT0 = {{(NREQ-1){1'b0}}, 1'b1};

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_BURST = 1'b1
    } state_t;

    state_t            r_state;
    logic [c_IW-1:0]   r_rr_ptr;
    logic [c_CW-1:0]   r_beat_cnt;

    logic              w_found;
    logic [c_IW-1:0]   w_pick;
    logic [c_IW-1:0]   w_scan_idx;
    logic              w_hold_rr;
    logic              w_own_valid;
    logic              w_own_last;
    logic [DSIZE-1:0]  w_own_data;
    logic [c_CW-1:0]   w_cnt_inc;

    // Round-robin search starting at rr_ptr; the index adds in c_IW bits,
    // so it wraps modulo NREQ for free (NREQ is a power of two).
    always_comb begin
        w_found    = 1'b0;
        w_pick     = '0;
        w_scan_idx = '0;
        w_hold_rr  = 1'b0;
        for (int k = 0; k < NREQ; k++) begin
            w_scan_idx = r_rr_ptr + c_IW'(k);
            if (!w_found && s_valid[w_scan_idx]) begin
                w_found = 1'b1;
                w_pick  = w_scan_idx;
            end
        end
`ifdef WARB_PRIO0_EN
        // Priority grant to requester 0 leaves the rotation untouched.
        if (s_valid[0]) begin
            w_found   = 1'b1;
            w_pick    = '0;
            w_hold_rr = 1'b1;
        end
`endif
    end

    assign busy        = (r_state == ST_BURST);
    assign w_own_valid = s_valid[gnt_id];
    assign w_own_last  = s_last[gnt_id];
    assign w_own_data  = s_data[gnt_id*DSIZE +: DSIZE];
    assign w_cnt_inc   = r_beat_cnt + c_CW'(1);

    // wfull is registered in the FIFO, so gating winc with it directly can
    // never push a word into a full FIFO.
    assign winc    = busy & w_own_valid & ~wfull;
    assign s_ready = (busy & ~wfull) ? grant : '0;
    assign wdata   = busy ? w_own_data : '0;

    always_ff @(posedge wclk or negedge wrst_n) begin
        if (!wrst_n) begin
            r_state    <= ST_IDLE;
            grant      <= '0;
            gnt_id     <= '0;
            r_rr_ptr   <= '0;
            r_beat_cnt <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_found) begin
                        r_state    <= ST_BURST;
                        grant      <= c_ONEHOT0 << w_pick;
                        gnt_id     <= w_pick;
                        r_beat_cnt <= '0;
                        if (!w_hold_rr) begin
                            r_rr_ptr <= w_pick + c_IW'(1);
                        end
                    end
                end
                ST_BURST: begin
                    // An owner that withdraws its request forfeits the burst.
                    if (!w_own_valid) begin
                        r_state    <= ST_IDLE;
                        grant      <= '0;
                        gnt_id     <= '0;
                        r_beat_cnt <= '0;
                    end else if (winc) begin
                        if (w_own_last || (w_cnt_inc == c_MAXCNT)) begin
                            r_state    <= ST_IDLE;
                            grant      <= '0;
                            gnt_id     <= '0;
                            r_beat_cnt <= '0;
                        end else begin
                            r_beat_cnt <= w_cnt_inc;
                        end
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    grant   <= '0;
                    gnt_id  <= '0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_fifo_write_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_fifo_write_arbiter
// Purpose  : Self-checking bench for fifo_write_arbiter: directed vector
//            table, async reset and back-to-back burst sequences, then
//            randomized traffic compared against a behavioural model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fifo_write_arbiter;

    localparam int NREQ     = 4;
    localparam int DSIZE    = 8;
    localparam int MAXBURST = 8;

    logic        wclk = 1'b0;
    logic        wrst_n;
    logic [3:0]  s_valid;
    logic [3:0]  s_last;
    logic [31:0] s_data;
    logic        wfull;
    logic [3:0]  s_ready;
    logic [3:0]  grant;
    logic [1:0]  gnt_id;
    logic        winc;
    logic [7:0]  wdata;
    logic        busy;
    logic [19:0] dut_out;

    fifo_write_arbiter #(.NREQ(NREQ), .DSIZE(DSIZE), .MAXBURST(MAXBURST)) dut (
        .wclk    (wclk),
        .wrst_n  (wrst_n),
        .s_valid (s_valid),
        .s_last  (s_last),
        .s_data  (s_data),
        .wfull   (wfull),
        .s_ready (s_ready),
        .grant   (grant),
        .gnt_id  (gnt_id),
        .winc    (winc),
        .wdata   (wdata),
        .busy    (busy)
    );

    always #5 wclk = ~wclk;

    assign dut_out = {grant, gnt_id, s_ready, winc, wdata, busy};

    int n_vec = 0;
    int n_bad = 0;

    // Reference model: owner (-1 when idle), rotation start, beats done.
    int m_owner;
    int m_rr;
    int m_beats;
    logic [3:0] last_xfer;

    // Recording of grant order / beats per grant.
    bit rec_en = 1'b0;
    bit prev_busy;
    int ord[16];
    int wr_cnt[16];
    int n_ord;

    typedef struct {
        logic [3:0]  v;
        logic [3:0]  l;
        logic [31:0] d;
        logic        f;
        logic [19:0] exp;
    } vec_t;

    vec_t tbl[12];

    function automatic vec_t mk(logic [3:0] v, logic [3:0] l, logic [31:0] d, logic f,
                                logic [3:0] g, logic [1:0] id, logic [3:0] r,
                                logic wi, logic [7:0] wd, logic b);
        vec_t t;
        t.v   = v;
        t.l   = l;
        t.d   = d;
        t.f   = f;
        t.exp = {g, id, r, wi, wd, b};
        return t;
    endfunction

    function automatic logic [19:0] model_out();
        logic [3:0] g;
        logic [1:0] id;
        logic [3:0] r;
        logic       wi;
        logic [7:0] wd;
        logic       b;
        g = '0; id = '0; r = '0; wi = 1'b0; wd = '0; b = 1'b0;
        if (m_owner >= 0) begin
            g  = 4'b0001 << m_owner;
            id = 2'(m_owner);
            r  = wfull ? 4'b0000 : g;
            wi = s_valid[m_owner] & ~wfull;
            wd = s_data[m_owner*8 +: 8];
            b  = 1'b1;
        end
        return {g, id, r, wi, wd, b};
    endfunction

    task automatic model_step();
        last_xfer = '0;
        if (m_owner < 0) begin
            if (s_valid != 4'b0000) begin
                m_beats = 0;
`ifdef WARB_PRIO0_EN
                if (s_valid[0]) begin
                    m_owner = 0;
                end else
`endif
                begin
                    for (int k = NREQ - 1; k >= 0; k--) begin
                        if (s_valid[(m_rr + k) % NREQ]) m_owner = (m_rr + k) % NREQ;
                    end
                    m_rr = (m_owner + 1) % NREQ;
                end
            end
        end else if (!s_valid[m_owner]) begin
            m_owner = -1;
        end else if (!wfull) begin
            last_xfer[m_owner] = 1'b1;
            m_beats++;
            if (s_last[m_owner] || m_beats == MAXBURST) m_owner = -1;
        end
    endtask

    task automatic check(string name, logic [19:0] exp);
        n_vec++;
        if (dut_out !== exp) begin
            n_bad++;
            $display("FAIL %s: got %05h expected %05h", name, dut_out, exp);
        end
    endtask

    // One clock: entered at posedge+1 with inputs already driven.
    task automatic cyc(string name);
        #3;
        check(name, model_out());
        if (rec_en) begin
            if (busy && !prev_busy && n_ord < 16) begin
                ord[n_ord] = int'(gnt_id);
                n_ord++;
            end
            if (winc && n_ord > 0) wr_cnt[n_ord-1]++;
            prev_busy = busy;
        end
        model_step();
        @(posedge wclk);
        #1;
    endtask

    task automatic new_word(int i);
        s_data[i*8 +: 8] = 8'($urandom);
        s_last[i]        = ($urandom % 4) == 0;
    endtask

    int stall_left = 0;

    task automatic drive_rand();
        for (int i = 0; i < NREQ; i++) begin
            if (last_xfer[i]) begin
                s_valid[i] = ($urandom % 4) != 0;
                new_word(i);
            end else if (!s_valid[i] && ($urandom % 3) == 0) begin
                s_valid[i] = 1'b1;
                new_word(i);
            end
        end
        if (stall_left > 0) begin
            stall_left--;
            wfull = 1'b1;
        end else if (($urandom % 8) == 0) begin
            stall_left = $urandom_range(0, 5);
            wfull = 1'b1;
        end else begin
            wfull = 1'b0;
        end
    endtask

    initial begin
        int exp_ord[5];
`ifdef WARB_PRIO0_EN
        exp_ord = '{0, 0, 0, 0, 0};
`else
        exp_ord = '{0, 1, 2, 3, 0};
`endif
        //            valid    last     data           f  grant   id     ready   wi   wdata  busy
        tbl[0]  = mk(4'b0100, 4'b0000, 32'h33A11100, 0, 4'b0000, 2'd0, 4'b0000, 0, 8'h00, 0);
        tbl[1]  = mk(4'b0100, 4'b0000, 32'h33A11100, 0, 4'b0100, 2'd2, 4'b0100, 1, 8'hA1, 1);
        tbl[2]  = mk(4'b0100, 4'b0000, 32'h33A21100, 0, 4'b0100, 2'd2, 4'b0100, 1, 8'hA2, 1);
        tbl[3]  = mk(4'b0100, 4'b0100, 32'h33A31100, 0, 4'b0100, 2'd2, 4'b0100, 1, 8'hA3, 1);
        tbl[4]  = mk(4'b0000, 4'b0000, 32'h33A31100, 0, 4'b0000, 2'd0, 4'b0000, 0, 8'h00, 0);
        tbl[5]  = mk(4'b1110, 4'b0000, 32'h33A31100, 0, 4'b0000, 2'd0, 4'b0000, 0, 8'h00, 0);
        tbl[6]  = mk(4'b1111, 4'b1000, 32'h33A31100, 1, 4'b1000, 2'd3, 4'b0000, 0, 8'h33, 1);
        tbl[7]  = mk(4'b1111, 4'b1000, 32'h33A31100, 0, 4'b1000, 2'd3, 4'b1000, 1, 8'h33, 1);
        tbl[8]  = mk(4'b1111, 4'b0000, 32'h33A31100, 0, 4'b0000, 2'd0, 4'b0000, 0, 8'h00, 0);
        tbl[9]  = mk(4'b1110, 4'b0000, 32'h33A31100, 0, 4'b0001, 2'd0, 4'b0001, 0, 8'h00, 1);
        tbl[10] = mk(4'b1110, 4'b0000, 32'h33A31100, 0, 4'b0000, 2'd0, 4'b0000, 0, 8'h00, 0);
        tbl[11] = mk(4'b0010, 4'b0010, 32'h33A31100, 0, 4'b0010, 2'd1, 4'b0010, 1, 8'h11, 1);

        // Reset
        wrst_n  = 1'b0;
        s_valid = '0;
        s_last  = '0;
        s_data  = '0;
        wfull   = 1'b0;
        m_owner = -1; m_rr = 0; m_beats = 0; last_xfer = '0;
        repeat (3) @(posedge wclk);
        #1;
        check("reset_state", 20'h00000);
        wrst_n = 1'b1;

        // Directed vector table
        for (int i = 0; i < 12; i++) begin
            s_valid = tbl[i].v;
            s_last  = tbl[i].l;
            s_data  = tbl[i].d;
            wfull   = tbl[i].f;
            #3;
            check($sformatf("vec%0d", i), tbl[i].exp);
            model_step();
            @(posedge wclk);
            #1;
        end

        // Async reset in the middle of a burst
        s_valid = 4'b0000; s_last = '0; wfull = 1'b0;
        cyc("drain");
        s_valid = 4'b0100; s_data = 32'h0055_0000;
        cyc("rst_arb");
        cyc("rst_beat1");
        wrst_n = 1'b0;
        #1;
        check("async_reset_outputs", 20'h00000);
        m_owner = -1; m_rr = 0; m_beats = 0; last_xfer = '0;
        @(posedge wclk);
        #1;
        wrst_n = 1'b1;

        // All requesters valid, no s_last: full bursts in rotation order
        s_valid = 4'b1111; s_last = '0; s_data = 32'h0403_0201;
        rec_en = 1'b1; prev_busy = 1'b0; n_ord = 0;
        for (int i = 0; i < 16; i++) wr_cnt[i] = 0;
        for (int c = 0; c < 45; c++) begin
            cyc("rr_bursts");
            for (int i = 0; i < NREQ; i++) begin
                if (last_xfer[i]) s_data[i*8 +: 8] = s_data[i*8 +: 8] + 8'h10;
            end
        end
        rec_en = 1'b0;
        for (int g = 0; g < 5; g++) begin
            n_vec++;
            if (g >= n_ord || ord[g] != exp_ord[g]) begin
                n_bad++;
                $display("FAIL grant_order[%0d]: got %0d expected %0d", g,
                         (g < n_ord) ? ord[g] : -1, exp_ord[g]);
            end
        end
        for (int g = 0; g < 4; g++) begin
            n_vec++;
            if (wr_cnt[g] != MAXBURST) begin
                n_bad++;
                $display("FAIL beats_per_grant[%0d]: got %0d expected %0d", g, wr_cnt[g], MAXBURST);
            end
        end

        // Randomized traffic with stalls, early ends and withdrawals
        for (int c = 0; c < 1500; c++) begin
            drive_rand();
            cyc("random");
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/fifo_write_arbiter.md
# fifo_write_arbiter

Write-side arbiter that shares the single write port of the asynchronous FIFO among NREQ requesters in the write clock domain. It grants one requester at a time in round-robin order, and the grant holds for a burst of up to MAXBURST beats. It gates writes with the FIFO's registered full flag and drives the FIFO's write increment and write data directly. It sits between the producer blocks and the FIFO write-pointer/full logic, and it runs entirely on wclk.

## Interface
- NREQ, 4: number of requesters; must be a power of two, ≥2.
- DSIZE, 8: data word width.
- MAXBURST, 8: maximum beats per grant; must be ≥1.

- wclk  input  1  write-domain clock; all state updates on rising edge.
- wrst_n  input  1  reset, asynchronous, active-low.
- s_valid  input  NREQ  per-requester word valid.
- s_last  input  NREQ  per-requester end-of-burst marker, qualified by a transfer.
- s_data  input  NREQ*DSIZE  requester i word at bits [i*DSIZE +: DSIZE].
- wfull  input  1  FIFO full flag (registered in FIFO).
- s_ready  output  NREQ  per-requester ready; a transfer occurs on s_valid[i] & s_ready[i].
- grant  output  NREQ  one-hot current owner; all-zero when idle.
- gnt_id  output  log2(NREQ)  binary index of owner; 0 when idle.
- winc  output  1  FIFO write increment.
- wdata  output  DSIZE  FIFO write data.
- busy  output  1  high in BURST state.

## Operation
- States: IDLE, BURST.
- Registered state: FSM state, grant, gnt_id, rr_ptr (log2 NREQ bits), beat_cnt (clog2(MAXBURST)+1 bits).
- IDLE behaviour:
  - If no s_valid is set, the block stays in IDLE.
  - Otherwise it selects the first i with s_valid[i] set, searching i = rr_ptr, rr_ptr+1, … modulo NREQ.
  - Next state is BURST, with grant = onehot(i), gnt_id = i, beat_cnt = 0, and rr_ptr = (i+1) mod NREQ.
- BURST outputs (combinational on registered grant):
  - s_ready[k] = grant[k] & ~wfull.
  - winc = s_valid[gnt_id] & ~wfull.
  - wdata = s_data[gnt_id].
- Outside BURST: s_ready = 0, winc = 0, wdata = 0.
- A transfer (winc=1) increments beat_cnt.
- BURST → IDLE, with grant cleared, on the first edge where any of these holds:
  - a transfer with s_last[gnt_id] = 1;
  - a transfer bringing beat_cnt to MAXBURST;
  - s_valid[gnt_id] = 0 (owner drops its request; no transfer that cycle).
- wfull high in BURST: winc = 0 and s_ready = 0. The grant holds and beat_cnt is unchanged. Stalls are unbounded.
- A requester's valid, data and last must stay stable while it is not ready.
- wfull is the FIFO's registered flag, which already reflects the write that filled the FIFO. Combinational winc therefore never issues a write when the FIFO is full, and no word is dropped.
- A requester that drops s_valid in BURST forfeits the rest of its burst.
- The rr_ptr arithmetic wraps modulo NREQ; NREQ-1 is followed by 0.

## Timing
- Reset: state = IDLE, grant = 0, gnt_id = 0, rr_ptr = 0, beat_cnt = 0. The combinational outputs follow: s_ready = 0, winc = 0, wdata = 0, busy = 0.
- Reset is asynchronous and may assert mid-burst. All outputs are zero immediately, and the partially transferred burst is abandoned.
- Arbitration latency: s_valid rising at edge n in IDLE gives grant at n+1. The first transfer can occur in the cycle after n+1 when wfull = 0.
- Throughput: one word per cycle within a burst.
- Each grant costs one IDLE bubble cycle between bursts.
- Full-flag interaction:
  - wfull asserting the cycle after the filling write blocks the next beat in the same cycle.
  - wfull deasserting resumes transfers in the same cycle.
- A single-beat burst (s_last on the first beat, or MAXBURST = 1) occupies exactly one BURST cycle when not stalled.

## Configuration
- WARB_PRIO0_EN defined: in IDLE, requester 0 wins whenever s_valid[0] = 1, regardless of rr_ptr. rr_ptr is not updated on such a grant. Other requesters use round-robin as normal.
- WARB_PRIO0_EN undefined: pure round-robin; requester 0 has no special treatment.

## Test plan
- Reset then single requester: s_valid[2]=1 with a 3-word burst A1,A2,A3, s_last on A3, wfull=0 → grant=0100 one cycle later; winc high 3 consecutive cycles; wdata = A1,A2,A3; then IDLE; rr_ptr=3.
- All four valid continuously, s_last never set, MAXBURST=8 → grants in order 0,1,2,3,0; 8 writes per grant; one idle cycle between grants.
- wfull driven high after the 2nd beat for 5 cycles → winc=0 and s_ready=0 for exactly those 5 cycles; grant held; beats 3..n follow with no loss or duplication (scoreboard matches).
- Owner drops s_valid after 1 beat → grant clears the next edge; the next valid requester is granted the cycle after that.
- wrst_n pulsed low mid-burst → grant, winc and s_ready are 0 asynchronously; after release, arbitration restarts from requester 0.
- With WARB_PRIO0_EN, requesters 0 and 1 both valid and rr_ptr=1 → requester 0 granted first; rr_ptr still 1, so requester 1 is granted next.
